// File: rtl/mandel_pixel_scheduler.sv
// Frame scheduler for the Mandelbrot datapath: walks the pixel grid in raster order,
// hands pixels to free iteration engines and funnels their results onto the frame-RAM port.
module mandel_pixel_scheduler #(
  parameter int NUM_ENG = 4,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int FX_W    = 18,
  parameter int COL_W   = 12
) (
  input  logic                      Clk_100M,
  input  logic                      Rst_n,
  input  logic                      frame_start,
  input  logic signed [FX_W-1:0]    c_real_start,
  input  logic signed [FX_W-1:0]    c_imag_start,
  input  logic signed [FX_W-1:0]    step,
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic [NUM_ENG-1:0]        eng_start,
  output logic signed [FX_W-1:0]    eng_c_real,
  output logic signed [FX_W-1:0]    eng_c_imag,
  output logic [ADDR_W-1:0]         eng_tag,
  input  logic [NUM_ENG-1:0]        eng_res_valid,
  output logic [NUM_ENG-1:0]        eng_res_ready,
  input  logic [NUM_ENG*ADDR_W-1:0] eng_res_tag,
  input  logic [NUM_ENG*COL_W-1:0]  eng_res_color,
  output logic [ADDR_W-1:0]         addrA,
  output logic [COL_W-1:0]          dinA,
  output logic                      wea
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int CW = $clog2(NUM_ENG + 1);

  localparam logic [XW-1:0]     X_LAST   = XW'(H_RES - 1);
  localparam logic [ADDR_W-1:0] TAG_LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [EW-1:0]     ENG_LAST = EW'(NUM_ENG - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [NUM_ENG-1:0]     busy_q, busy_d;
  logic [CW-1:0]          outst_q, outst_d;
  logic [EW-1:0]          ptr_q, ptr_d;
  logic [XW-1:0]          x_q, x_d;
  logic [ADDR_W-1:0]      tag_q, tag_d;
  logic signed [FX_W-1:0] cr0_q, cr0_d;
  logic signed [FX_W-1:0] step_q, step_d;
  logic signed [FX_W-1:0] c_real_q, c_real_d;
  logic signed [FX_W-1:0] c_imag_q, c_imag_d;
  logic                   wea_q, wea_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [COL_W-1:0]       din_q, din_d;

  logic [NUM_ENG-1:0]     req;
  logic                   grant_vld;
  logic [EW-1:0]          grant_idx;
  logic                   start_vld;
  logic [EW-1:0]          start_idx;
  int                     j;

  always_comb begin
    // Results only count from engines we actually started; stray valids are masked.
    req       = eng_res_valid & busy_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_ENG) j = j - NUM_ENG;
      if (!grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant_idx = EW'(j);
      end
    end

    start_vld = 1'b0;
    start_idx = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (!start_vld && !busy_q[k]) begin
        start_vld = 1'b1;
        start_idx = EW'(k);
      end
    end
    start_vld = start_vld && (state_q == S_DISPATCH);

    eng_start     = start_vld ? (NUM_ENG'(1) << start_idx) : '0;
    eng_res_ready = grant_vld ? (NUM_ENG'(1) << grant_idx) : '0;

    // Set after clear so a same-edge restart keeps the engine busy.
    busy_d = (busy_q & ~eng_res_ready) | eng_start;

    case ({start_vld, grant_vld})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_idx == ENG_LAST) ? '0 : grant_idx + EW'(1);

    wea_d  = grant_vld;
    addr_d = addr_q;
    din_d  = din_q;
    if (grant_vld) begin
      addr_d = eng_res_tag[int'(grant_idx)*ADDR_W +: ADDR_W];
      din_d  = eng_res_color[int'(grant_idx)*COL_W +: COL_W];
    end

    state_d  = state_q;
    x_d      = x_q;
    tag_d    = tag_q;
    cr0_d    = cr0_q;
    step_d   = step_q;
    c_real_d = c_real_q;
    c_imag_d = c_imag_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d  = S_DISPATCH;
          cr0_d    = c_real_start;
          step_d   = step;
          c_real_d = c_real_start;
          c_imag_d = c_imag_start;
          x_d      = '0;
          tag_d    = '0;
        end
      end
      S_DISPATCH: begin
        // Row/column accumulators stand in for x*step and y*step multipliers.
        if (start_vld) begin
          tag_d = tag_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d      = '0;
            c_real_d = cr0_q;
            c_imag_d = c_imag_q - step_q;
          end else begin
            x_d      = x_q + XW'(1);
            c_real_d = c_real_q + step_q;
          end
          if (tag_q == TAG_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0 && !grant_vld) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= '0;
      outst_q  <= '0;
      ptr_q    <= '0;
      x_q      <= '0;
      tag_q    <= '0;
      cr0_q    <= '0;
      step_q   <= '0;
      c_real_q <= '0;
      c_imag_q <= '0;
      wea_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      outst_q  <= outst_d;
      ptr_q    <= ptr_d;
      x_q      <= x_d;
      tag_q    <= tag_d;
      cr0_q    <= cr0_d;
      step_q   <= step_d;
      c_real_q <= c_real_d;
      c_imag_q <= c_imag_d;
      wea_q    <= wea_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign frame_busy = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
  assign frame_done = (state_q == S_DONE);
  assign eng_c_real = c_real_q;
  assign eng_c_imag = c_imag_q;
  assign eng_tag    = tag_q;
  assign wea        = wea_q;
  assign addrA      = addr_q;
  assign dinA       = din_q;

endmodule
